// File: rtl/sound_frame_seq.sv
// sound_frame_seq: APU timing/trigger controller - base-frequency strobe, 512 Hz frame sequencer, channel start pulses
// Ports:
//   clk            CPU clock (4194304 Hz)
//   rst            synchronous active-high reset
//   apu_en         NR52 bit 7; low holds everything cleared and ignores triggers
//   trig_wr        per-channel NRx4 trigger strobe
//   div_bit        DIV bit 12, frame-sequencer source only when FS_EXT_DIV_EN is defined
//   freq_div_tick  one-cycle pulse every FREQ_DIV clocks
//   length_tick    256 Hz one-cycle tick
//   sweep_tick     128 Hz one-cycle tick
//   env_tick       64 Hz one-cycle tick
//   step           current frame-sequencer step 0-7
//   start          per-channel start level, START_HOLD clocks per trigger
// Optional macro FS_EXT_DIV_EN: step advances on falling edges of div_bit instead of the internal prescaler.
module sound_frame_seq #(
  parameter int FS_DIV = 8192,
  parameter int FREQ_DIV = 4,
  parameter int START_HOLD = 4,
  parameter int NUM_CH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              apu_en,
  input  logic [NUM_CH-1:0] trig_wr,
  input  logic              div_bit,
  output logic              freq_div_tick,
  output logic              length_tick,
  output logic              sweep_tick,
  output logic              env_tick,
  output logic [2:0]        step,
  output logic [NUM_CH-1:0] start
);
  localparam int FW = $clog2(FREQ_DIV);
  localparam int HW = $clog2(START_HOLD + 1);
  localparam logic [FW-1:0] F_MAX = FW'(FREQ_DIV - 1);
  localparam logic [HW-1:0] H_LOAD = HW'(START_HOLD);
  logic adv;
  logic [FW-1:0] fcnt;
  logic [2:0] nstep;
  logic [HW-1:0] hold [NUM_CH];
  assign nstep = step + 3'd1;
  always_ff @(posedge clk)
    if (rst || !apu_en) begin
      fcnt <= '0;
      freq_div_tick <= 1'b0;
    end else begin
      fcnt <= (fcnt == F_MAX) ? '0 : fcnt + 1'b1;
      freq_div_tick <= (fcnt == F_MAX);
    end
`ifdef FS_EXT_DIV_EN
  logic div_q, div_d;
  always_ff @(posedge clk)
    if (rst || !apu_en) begin
      div_q <= 1'b0;
      div_d <= 1'b0;
    end else begin
      div_q <= div_bit;
      div_d <= div_q;
    end
  // falling edge of the registered DIV bit
  assign adv = div_d & ~div_q;
`else
  localparam int PW = $clog2(FS_DIV);
  localparam logic [PW-1:0] P_MAX = PW'(FS_DIV - 1);
  logic [PW-1:0] presc;
  logic unused_div_bit;
  assign unused_div_bit = div_bit;
  always_ff @(posedge clk)
    if (rst || !apu_en) presc <= '0;
    else presc <= (presc == P_MAX) ? '0 : presc + 1'b1;
  assign adv = (presc == P_MAX);
`endif
  // ticks are decoded from the step being entered so they land together with the new step value
  always_ff @(posedge clk)
    if (rst || !apu_en) begin
      step <= 3'd0;
      length_tick <= 1'b0;
      sweep_tick <= 1'b0;
      env_tick <= 1'b0;
    end else begin
      if (adv) step <= nstep;
      length_tick <= adv & ~nstep[0];
      sweep_tick <= adv & (nstep[1:0] == 2'd2);
      env_tick <= adv & (nstep == 3'd7);
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    always_ff @(posedge clk)
      if (rst || !apu_en) hold[i] <= '0;
      else if (trig_wr[i]) hold[i] <= H_LOAD;
      else if (hold[i] != '0) hold[i] <= hold[i] - 1'b1;
    assign start[i] = (hold[i] != '0);
  end
endmodule

// File: tb/tb_sound_frame_seq.sv
// tb_sound_frame_seq: randomized and directed bench for sound_frame_seq against a cycle-count model
module tb_sound_frame_seq;
  localparam int FS = 2048;
  localparam int NC = 4;
  localparam int SH = 4;
  logic clk = 1'b0, rst = 1'b1, apu_en = 1'b0, div_bit = 1'b0;
  logic [NC-1:0] trig_wr = '0;
  logic freq_div_tick, length_tick, sweep_tick, env_tick;
  logic [2:0] step;
  logic [NC-1:0] start;
  logic div_auto = 1'b1;
  logic [3:0] dcnt = '0;
  int checks = 0, errors = 0;
  int m_cyc = 0, m_n = 0, m_step = 0;
  bit m_fdt, m_len, m_sw, m_env, m_h1, m_h2;
  int m_last [NC] = '{default: -100};

  sound_frame_seq #(.FS_DIV(FS), .FREQ_DIV(4), .START_HOLD(SH), .NUM_CH(NC)) dut (
    .clk(clk), .rst(rst), .apu_en(apu_en), .trig_wr(trig_wr), .div_bit(div_bit),
    .freq_div_tick(freq_div_tick), .length_tick(length_tick), .sweep_tick(sweep_tick),
    .env_tick(env_tick), .step(step), .start(start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit adv_next();
`ifdef FS_EXT_DIV_EN
    return m_h2 && !m_h1;
`else
    return ((m_n + 1) % FS) == 0;
`endif
  endfunction

  // model: everything follows from the number of enabled edges and the edge of each honoured trigger
  task automatic model_edge();
    bit adv;
    m_cyc++;
    if (rst || !apu_en) begin
      m_n = 0; m_step = 0; m_fdt = 0; m_len = 0; m_sw = 0; m_env = 0; m_h1 = 0; m_h2 = 0;
      for (int i = 0; i < NC; i++) m_last[i] = -100;
    end else begin
`ifdef FS_EXT_DIV_EN
      adv = m_h2 && !m_h1;
      m_h2 = m_h1;
      m_h1 = div_bit;
`else
      adv = ((m_n + 1) % FS) == 0;
`endif
      m_fdt = ((m_n + 1) % 4) == 0;
      m_n++;
      if (adv) m_step = (m_step + 1) % 8;
      m_len = adv && (m_step % 2 == 0);
      m_sw = adv && (m_step == 2 || m_step == 6);
      m_env = adv && (m_step == 7);
      for (int i = 0; i < NC; i++) if (trig_wr[i]) m_last[i] = m_cyc;
    end
  endtask

  task automatic compare();
    logic [NC-1:0] exp_start;
    for (int i = 0; i < NC; i++) exp_start[i] = (m_cyc - m_last[i]) < SH;
    chk("step", step, m_step);
    chk("freq_div_tick", freq_div_tick, m_fdt);
    chk("length_tick", length_tick, m_len);
    chk("sweep_tick", sweep_tick, m_sw);
    chk("env_tick", env_tick, m_env);
    chk("start", start, exp_start);
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(posedge clk);
    #1;
    compare();
  end

  initial forever begin
    @(negedge clk);
    dcnt = dcnt + 1'b1;
    div_bit = div_auto ? dcnt[3] : 1'b1;
  end

  initial begin
    int fdt_n, fdt_first, n_len, n_sw, n_env, n_chg, last_chg, ka, s0, prev, w, fa;
    fdt_n = 0; fdt_first = 0; n_len = 0; n_sw = 0; n_env = 0; n_chg = 0; last_chg = 0; ka = 0; s0 = 0; prev = 0;
    repeat (3) @(negedge clk);
    chk("rst_step", step, 0);
    chk("rst_start", start, 0);
    chk("rst_ticks", {freq_div_tick, length_tick, sweep_tick, env_tick}, 0);
    rst = 1'b0;
    apu_en = 1'b1;
    for (int k = 1; k <= 8 * FS; k++) begin
      @(negedge clk);
      if (k <= 100 && freq_div_tick) begin
        fdt_n++;
        if (fdt_first == 0) fdt_first = k;
      end
      n_len += int'(length_tick);
      n_sw += int'(sweep_tick);
      n_env += int'(env_tick);
      if (int'(step) != prev) begin
`ifdef FS_EXT_DIV_EN
        if (last_chg != 0) chk("adv_spacing", k - last_chg, 16);
`endif
        n_chg++;
        last_chg = k;
        prev = int'(step);
      end
`ifndef FS_EXT_DIV_EN
      if (k == FS - 1) chk("step_before_first_adv", step, 0);
      if (k == FS) chk("step_first_adv", step, 1);
`endif
      if (k >= 301 && k <= 305) chk("start0_hold", start[0], int'(k <= 304));
      if (k == 302) chk("start_other_idle", start[3:1], 0);
      if (k >= 601 && k <= 607) chk("start2_retrig", start[2], int'(k <= 606));
      if (ka != 0 && k == ka + 1) chk("step_with_trig", step, (s0 + 1) % 8);
      if (ka != 0 && k > ka && k <= ka + 5) chk("start13_at_adv", {start[3], start[1]}, (k <= ka + 4) ? 3 : 0);
      trig_wr = '0;
      if (k == 300) trig_wr[0] = 1'b1;
      if (k == 600 || k == 602) trig_wr[2] = 1'b1;
      if (ka == 0 && k >= 900 && adv_next()) begin
        trig_wr = 4'b1010;
        ka = k;
        s0 = int'(step);
      end
    end
    chk("fdt_count", fdt_n, 25);
    chk("fdt_first", fdt_first, 4);
    chk("adv_trig_seen", int'(ka != 0), 1);
`ifndef FS_EXT_DIV_EN
    chk("length_count", n_len, 4);
    chk("sweep_count", n_sw, 2);
    chk("env_count", n_env, 1);
    chk("step_changes", n_chg, 8);
    chk("step_after_lap", step, 0);
`endif
    w = 0;
    while (step != 3'd5 && w < 10 * FS) begin
      @(negedge clk);
      w++;
    end
    chk("reach_step5", step, 5);
    trig_wr = 4'b0001;
    @(negedge clk);
    trig_wr = '0;
    @(negedge clk);
    chk("start0_midhold", start[0], 1);
    apu_en = 1'b0;
    @(negedge clk);
    chk("off_step", step, 0);
    chk("off_start", start, 0);
    trig_wr = '1;
    @(negedge clk);
    trig_wr = '0;
    @(negedge clk);
    chk("off_trig_ignored", start, 0);
    apu_en = 1'b1;
    fa = 0;
    for (int k = 1; k <= FS + 20; k++) begin
      @(negedge clk);
      if (fa == 0 && step != 3'd0) fa = k;
    end
`ifndef FS_EXT_DIV_EN
    chk("reenable_first_adv", fa, FS);
`else
    chk("reenable_adv_seen", int'(fa != 0), 1);
    div_auto = 1'b0;
    repeat (3) @(negedge clk);
    s0 = int'(step);
    repeat (100) @(negedge clk);
    chk("div_high_no_adv", step, s0);
    div_auto = 1'b1;
`endif
    for (int k = 0; k < 20000; k++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 3999) == 0);
      apu_en = ($urandom_range(0, 2999) != 0);
      trig_wr = ($urandom_range(0, 5) == 0) ? NC'($urandom) : '0;
    end
    rst = 1'b0;
    apu_en = 1'b1;
    trig_wr = '0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
